// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage plus IF/ID register with branch-delay-slot redirect
// and a one-entry holding buffer for words returned while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_D,
  input  logic          flush_D,
  input  logic          pc_src_D,
  input  logic [31:0]   next_br_D,
  fetch_stage_if.master imem,
  output logic [31:0]   inst_D,
  output logic [31:0]   PC_plus_4_D,
  output logic          valid_D,
  output logic          fetch_busy
);

  localparam logic [0:0] REQ = 1'b0;
  localparam logic [0:0] BUF = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_F, pc4_F, npc, br_tgt;
  logic [31:0] redir_pc, buf_inst, buf_pc4;
  logic        redir_pend, redirect_now, hs;

  assign redirect_now = pc_src_D & ~stall_D;
  assign br_tgt       = {next_br_D[31:2], 2'b00};
  assign pc4_F        = pc_F + 32'd4;
  // A redirect captured during a wait outranks one arriving on the handshake cycle.
  assign npc          = redir_pend ? redir_pc : (redirect_now ? br_tgt : pc4_F);

  assign imem.req   = (state == REQ) & ~reset;
  assign imem.addr  = pc_F;
  assign hs         = imem.req & imem.ready;
  assign fetch_busy = imem.req & ~imem.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F        <= RESET_PC;
      state       <= REQ;
      redir_pend  <= 1'b0;
      redir_pc    <= RESET_PC;
      buf_inst    <= NOP_INST;
      buf_pc4     <= 32'd0;
      inst_D      <= NOP_INST;
      PC_plus_4_D <= 32'd0;
      valid_D     <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (hs) begin
            pc_F       <= npc;
            redir_pend <= 1'b0;
            if (stall_D) begin
              buf_inst <= imem.rdata;
              buf_pc4  <= pc4_F;
              state    <= BUF;
            end else begin
              inst_D      <= imem.rdata;
              PC_plus_4_D <= pc4_F;
              valid_D     <= 1'b1;
            end
          end else begin
            if (!stall_D) begin
              inst_D  <= NOP_INST;
              valid_D <= 1'b0;
            end
            // imem_addr must stay put while waiting, so the target is parked.
            if (redirect_now) begin
              redir_pc   <= br_tgt;
              redir_pend <= 1'b1;
            end
          end
        end
        BUF: begin
          if (!stall_D) begin
            inst_D      <= buf_inst;
            PC_plus_4_D <= buf_pc4;
            valid_D     <= 1'b1;
            state       <= REQ;
          end
          if (redirect_now) pc_F <= br_tgt;
        end
        default: state <= REQ;
      endcase
      if (flush_D) begin
        inst_D  <= NOP_INST;
        valid_D <= 1'b0;
        if (state == BUF) state <= REQ;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a fetch-stream reference model.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset, stall_D, flush_D, pc_src_D, rdy;
  logic [31:0] next_br_D, inst_D, PC_plus_4_D;
  logic        valid_D, fetch_busy;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  fetch_stage_if imem();
  assign imem.ready = rdy;
  assign imem.rdata = memf(imem.addr);

  fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .flush_D(flush_D),
    .pc_src_D(pc_src_D), .next_br_D(next_br_D), .imem(imem.master),
    .inst_D(inst_D), .PC_plus_4_D(PC_plus_4_D), .valid_D(valid_D),
    .fetch_busy(fetch_busy)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;

  // Model: cur = address being (or next to be) fetched, nxt = address fetched after it,
  // held = one fetched word waiting for decode, ifid = what decode should see.
  logic [31:0] m_cur, m_nxt, m_hold_inst, m_hold_pc4, m_inst, m_pc4;
  logic        m_held, m_redir, m_v;

  task automatic model_reset();
    m_cur = RPC; m_nxt = RPC + 32'd4; m_held = 0; m_redir = 0;
    m_v = 0; m_inst = NOP; m_pc4 = 32'd0;
  endtask

  task automatic model_step();
    logic rn, had_held;
    logic [31:0] t;
    if (reset) begin
      model_reset();
      return;
    end
    rn = pc_src_D & ~stall_D;
    t = {next_br_D[31:2], 2'b00};
    had_held = m_held;
    if (!m_held) begin
      if (rn && !(rdy && m_redir)) begin m_nxt = t; m_redir = 1; end
      if (rdy) begin
        if (stall_D) begin
          m_hold_inst = memf(m_cur); m_hold_pc4 = m_cur + 32'd4; m_held = 1;
        end else begin
          m_inst = memf(m_cur); m_pc4 = m_cur + 32'd4; m_v = 1;
        end
        m_cur = m_nxt; m_nxt = m_cur + 32'd4; m_redir = 0;
      end else if (!stall_D) begin
        m_inst = NOP; m_v = 0;
      end
    end else begin
      if (!stall_D) begin
        m_inst = m_hold_inst; m_pc4 = m_hold_pc4; m_v = 1; m_held = 0;
      end
      if (rn) begin m_cur = t; m_nxt = t + 32'd4; end
    end
    if (flush_D) begin
      m_inst = NOP; m_v = 0;
      if (had_held) m_held = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_req", {31'd0, imem.req}, {31'd0, e.req});
      if (e.req) chk("imem_addr", imem.addr, e.addr);
      chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, e.busy});
      chk("valid_D", {31'd0, valid_D}, {31'd0, e.v});
      chk("inst_D", inst_D, e.inst);
      if (e.v) chk("PC_plus_4_D", PC_plus_4_D, e.pc4);
    end
  end

  initial begin
    exp_t e;
    reset = 1; stall_D = 0; flush_D = 0; pc_src_D = 0; next_br_D = 0; rdy = 0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #2;
      if (c < 3) begin
        reset = 1; rdy = $urandom_range(0, 1) == 1;
        stall_D = 0; flush_D = 0; pc_src_D = 0;
      end else if (c < 30) begin
        // Streaming warm-up: one word per cycle.
        reset = 0; rdy = 1; stall_D = 0; flush_D = 0; pc_src_D = 0;
      end else begin
        reset    = ($urandom_range(0, 199) == 0);
        rdy      = ($urandom_range(0, 2) != 0);
        stall_D  = ($urandom_range(0, 3) == 0);
        flush_D  = stall_D && ($urandom_range(0, 3) == 0);
        pc_src_D = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) next_br_D = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
        else next_br_D = $urandom_range(0, 1023);
      end
      e.req  = !reset && !m_held;
      e.addr = m_cur;
      e.busy = e.req && !rdy;
      e.v    = m_v;
      e.inst = m_inst;
      e.pc4  = m_pc4;
      q.push_back(e);
      model_step();
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() != 0) $display("FAIL drain: got %0d pending expected 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
